debug_host_ctrl: RTL

// - Host-side initiator for debug_harness: decodes a byte-stream command protocol from the host link into
//   ROM programming writes and debug commands, waits for completion, and returns one status byte per command.
// - Sits between the host byte link (UART or testbench shim) and debug_harness; clk and hclk of the

---
 rtl/debug_pkg.sv | 54 +++++
 rtl/debug_host_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/debug_pkg.sv
// Shared encodings for the host debug link: opcodes, status bytes, harness
// command values and the host controller state type.
package debug_pkg;

  localparam logic [7:0] OP_LOAD    = 8'h01;
  localparam logic [7:0] OP_RUN     = 8'h02;
  localparam logic [7:0] OP_STEPI   = 8'h03;
  localparam logic [7:0] OP_STEPC   = 8'h04;
  localparam logic [7:0] OP_CLR_ROM = 8'h05;

  localparam logic [7:0] RESP_LOAD_OK = 8'hA1;
  localparam logic [7:0] RESP_CLR_OK  = 8'hA5;
  localparam logic [7:0] RESP_BAD_OP  = 8'hEE;

  localparam int unsigned RESP_DONE_BIT    = 7;
  localparam int unsigned RESP_EXIT_BIT    = 1;
  localparam int unsigned RESP_TIMEOUT_BIT = 0;

  localparam logic [3:0] DBG_NONE  = 4'd0;
  localparam logic [3:0] DBG_RUN   = 4'd1;
  localparam logic [3:0] DBG_STEPI = 4'd2;
  localparam logic [3:0] DBG_STEPC = 4'd3;

  typedef enum logic [2:0] {
    IDLE,
    LD_HDR,
    LD_DATA,
    CMD_ISSUE,
    CMD_WAIT,
    ROM_CLR,
    RESP
  } state_t;

  function automatic logic [3:0] op_to_dbg(input logic [7:0] op);
    logic [3:0] r;
    case (op)
      OP_RUN:   r = DBG_RUN;
      OP_STEPI: r = DBG_STEPI;
      OP_STEPC: r = DBG_STEPC;
      default:  r = DBG_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] cmd_resp(input logic exited, input logic timed_out);
    logic [7:0] r;
    r                   = '0;
    r[RESP_DONE_BIT]    = 1'b1;
    r[RESP_EXIT_BIT]    = exited;
    r[RESP_TIMEOUT_BIT] = timed_out;
    return r;
  endfunction

endpackage

// File: rtl/debug_host_ctrl.sv
// Host-side byte protocol decoder driving ROM programming and debug commands
// into debug_harness, returning one status byte per command.
module debug_host_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic [3:0]        debug_cmd,
  output logic [ADDR_W-1:0] code_rom_addr_in,
  output logic [7:0]        code_rom_data_in,
  output logic              program_rom_mode,
  output logic              reset_code_rom_n,
  input  logic              command_complete,
  input  logic              exit_signal
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_d;
  logic [2:0]        hdr_idx, hdr_idx_d;
  logic [3:0]        addr_hi, addr_hi_d;
  logic [7:0]        len_hi, len_hi_d;
  logic [15:0]       remaining, remaining_d;
  logic [ADDR_W-1:0] wr_addr, wr_addr_d;
  logic [3:0]        cmd, cmd_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic [7:0]        resp, resp_d;

  logic [3:0]        debug_cmd_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [7:0]        rom_data_d;
  logic              rom_we_d;
  logic              rom_clr_n_d;
  logic              rx_fire;

  // Gated by reset so no byte is consumed while the state register is still settling.
  assign rx_ready = !reset && ((state == IDLE) || (state == LD_HDR) || (state == LD_DATA));
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_valid = (state == RESP);
  assign tx_data  = resp;

  always_comb begin
    state_d     = state;
    hdr_idx_d   = hdr_idx;
    addr_hi_d   = addr_hi;
    len_hi_d    = len_hi;
    remaining_d = remaining;
    wr_addr_d   = wr_addr;
    cmd_d       = cmd;
    wait_cnt_d  = wait_cnt;
    resp_d      = resp;
    debug_cmd_d = DBG_NONE;
    rom_addr_d  = code_rom_addr_in;
    rom_data_d  = code_rom_data_in;
    rom_we_d    = 1'b0;
    rom_clr_n_d = 1'b1;

    case (state)
      IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            OP_LOAD: begin
              hdr_idx_d = '0;
              state_d   = LD_HDR;
            end
            OP_RUN, OP_STEPI, OP_STEPC: begin
              cmd_d   = op_to_dbg(rx_data);
              state_d = CMD_ISSUE;
            end
            OP_CLR_ROM: state_d = ROM_CLR;
            default: begin
              resp_d  = RESP_BAD_OP;
              state_d = RESP;
            end
          endcase
        end
      end

      LD_HDR: begin
        if (rx_fire) begin
          hdr_idx_d = hdr_idx + 3'd1;
          case (hdr_idx)
            3'd0:    addr_hi_d = rx_data[3:0];
            3'd1:    wr_addr_d = ADDR_W'({addr_hi, rx_data});
            3'd2:    len_hi_d  = rx_data;
            default: begin
              remaining_d = {len_hi, rx_data};
              if ({len_hi, rx_data} == 16'd0) begin
                resp_d  = RESP_LOAD_OK;
                state_d = RESP;
              end else begin
                state_d = LD_DATA;
              end
            end
          endcase
        end
      end

      LD_DATA: begin
        if (rx_fire) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = wr_addr;
          rom_data_d  = rx_data;
          // Plain ADDR_W-bit increment gives the silent wrap at the top of the ROM.
          wr_addr_d   = wr_addr + ADDR_W'(1);
          remaining_d = remaining - 16'd1;
          if (remaining == 16'd1) begin
            resp_d  = RESP_LOAD_OK;
            state_d = RESP;
          end
        end
      end

      CMD_ISSUE: begin
        wait_cnt_d = '0;
        if (exit_signal) begin
          resp_d  = cmd_resp(1'b1, 1'b0);
          state_d = RESP;
        end else begin
          debug_cmd_d = cmd;
          state_d     = CMD_WAIT;
        end
      end

      CMD_WAIT: begin
        if (command_complete) begin
          resp_d  = cmd_resp(exit_signal, 1'b0);
          state_d = RESP;
        end else if (wait_cnt == CNT_LAST) begin
          resp_d  = cmd_resp(exit_signal, 1'b1);
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end

      ROM_CLR: begin
        rom_clr_n_d = 1'b0;
        resp_d      = RESP_CLR_OK;
        state_d     = RESP;
      end

      RESP: begin
        if (tx_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      hdr_idx          <= '0;
      addr_hi          <= '0;
      len_hi           <= '0;
      remaining        <= '0;
      wr_addr          <= '0;
      cmd              <= DBG_NONE;
      wait_cnt         <= '0;
      resp             <= '0;
      debug_cmd        <= DBG_NONE;
      code_rom_addr_in <= '0;
      code_rom_data_in <= '0;
      program_rom_mode <= 1'b0;
      reset_code_rom_n <= 1'b1;
    end else begin
      state            <= state_d;
      hdr_idx          <= hdr_idx_d;
      addr_hi          <= addr_hi_d;
      len_hi           <= len_hi_d;
      remaining        <= remaining_d;
      wr_addr          <= wr_addr_d;
      cmd              <= cmd_d;
      wait_cnt         <= wait_cnt_d;
      resp             <= resp_d;
      debug_cmd        <= debug_cmd_d;
      code_rom_addr_in <= rom_addr_d;
      code_rom_data_in <= rom_data_d;
      program_rom_mode <= rom_we_d;
      reset_code_rom_n <= rom_clr_n_d;
    end
  end

endmodule
